periph_frame_sequencer: RTL and testbench

- Parametrised successor of the front-panel refresh sequencer.
- Runs one refresh frame per `Enable` assertion over `NUM_SLOTS` peripheral write slots, e.g. IN-12 cathodes, IN-12 anodes, keyboard write, MS6205 address, MS6205 data.
- Each slot gets a programmable setup, strobe and hold timing. Slots not flagged in the per-frame request mask are skipped.
- A read-back strobe (keyboard read) closes each frame once `Enable` falls. Sits between the emulator core and the panel drivers.

---
 rtl/panel_seq_pkg.sv | 26 ++
 rtl/lowest_bit_sel.sv | 25 ++
 rtl/periph_frame_sequencer.sv | 168 ++++++++++++++++
 tb/tb_periph_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_seq_pkg.sv
// rtl/panel_seq_pkg.sv - shared state encoding and slot-order constants for the panel frame sequencer
// Contents: seq_state_t (3-bit FSM codes), default slot order, timing-counter reload helper.
package panel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_REL = 3'd4,
        ST_READBACK = 3'd5
    } seq_state_t;

    // Default slot order on the front panel; slot 0 is serviced first.
    localparam int SLOT_CATHODE = 0;
    localparam int SLOT_ANODE   = 1;
    localparam int SLOT_KBD_WR  = 2;
    localparam int SLOT_MC_ADDR = 3;
    localparam int SLOT_MC_DATA = 4;

    // The timing counter counts down to zero, so a phase of N cycles reloads N-1.
    function automatic logic [3:0] cnt_load(input int cycles);
        return (cycles > 0) ? 4'(cycles - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/lowest_bit_sel.sv
// rtl/lowest_bit_sel.sv - priority encoder returning the lowest set bit of a mask
// Ports: mask (in, WIDTH) request bits; idx (out, IDX_W) position of lowest set bit;
//        any (out) mask is non-zero. idx is 0 when any is 0.
module lowest_bit_sel #(
    parameter int WIDTH = 6,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the last hit, the lowest bit, wins.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/periph_frame_sequencer.sv
// rtl/periph_frame_sequencer.sv - front-panel refresh frame sequencer with programmable slot timing
// Ports: Clock_1us (in) clock; Rst_n (in) sync active-low reset; Enable (in) frame request level;
//        slot_req (in, NUM_SLOTS) per-frame slot mask; slot_strobe (out, NUM_SLOTS) one-hot write strobe;
//        slot_index (out, IDX_W) slot being serviced; read_strobe (out) read-back pulse;
//        busy (out) not idle; frame_done (out) end-of-frame pulse; aborted (out) last frame cut short;
//        state (out, 3) current FSM state code.
module periph_frame_sequencer
    import panel_seq_pkg::*;
#(
    parameter int NUM_SLOTS    = 6,
    parameter int SETUP_CYCLES = 1,
    parameter int STROBE_WIDTH = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int IDX_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 Clock_1us,
    input  logic                 Rst_n,
    input  logic                 Enable,
    input  logic [NUM_SLOTS-1:0] slot_req,
    output logic [NUM_SLOTS-1:0] slot_strobe,
    output logic [IDX_W-1:0]     slot_index,
    output logic                 read_strobe,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 aborted,
    output logic [2:0]           state
);

    localparam logic [3:0] SETUP_LOAD  = cnt_load(SETUP_CYCLES);
    localparam logic [3:0] STROBE_LOAD = cnt_load(STROBE_WIDTH);
    localparam logic [3:0] HOLD_LOAD   = cnt_load(HOLD_CYCLES);
    // A zero-length setup enters the strobe directly from slot selection.
    localparam seq_state_t SLOT_ENTRY  = (SETUP_CYCLES == 0) ? ST_STROBE : ST_SETUP;
    localparam logic [3:0] ENTRY_LOAD  = (SETUP_CYCLES == 0) ? STROBE_LOAD : SETUP_LOAD;

    seq_state_t           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d, sel_mask, serviced;
    logic                 drop_q, drop_d, aborted_d, slot_exit, sel_any;
    logic [IDX_W-1:0]     index_d, sel_idx;

    // In IDLE the encoder looks at the incoming request so the first slot is chosen on the
    // capture edge; otherwise it looks at what remains once the current slot is retired.
    assign serviced = NUM_SLOTS'(1) << slot_index;
    assign sel_mask = (state_q == ST_IDLE) ? slot_req : (mask_q & ~serviced);

    lowest_bit_sel #(
        .WIDTH (NUM_SLOTS),
        .IDX_W (IDX_W)
    ) u_sel (
        .mask (sel_mask),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        drop_d    = drop_q;
        index_d   = slot_index;
        aborted_d = aborted;
        slot_exit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    mask_d    = slot_req;
                    aborted_d = 1'b0;
                    drop_d    = 1'b0;
                    if (sel_any) begin
                        state_d = SLOT_ENTRY;
                        cnt_d   = ENTRY_LOAD;
                        index_d = sel_idx;
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end
            end
            ST_SETUP: begin
                // Release before the strobe drops this slot without strobing it.
                if (!Enable) begin
                    state_d   = ST_READBACK;
                    aborted_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                // Release once strobing has begun is remembered; the slot still finishes.
                drop_d = drop_q | ~Enable;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (HOLD_CYCLES == 0) begin
                    slot_exit = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                drop_d = drop_q | ~Enable;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    slot_exit = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!Enable) begin
                    state_d = ST_READBACK;
                end
            end
            ST_READBACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retire the serviced slot and jump straight to the next requested one.
        if (slot_exit) begin
            mask_d = mask_q & ~serviced;
            if (drop_q || !Enable) begin
                state_d   = ST_READBACK;
                aborted_d = 1'b1;
            end else if (sel_any) begin
                state_d = SLOT_ENTRY;
                cnt_d   = ENTRY_LOAD;
                index_d = sel_idx;
            end else begin
                state_d = ST_WAIT_REL;
            end
        end
    end

    // Output flops are loaded from the next state so they change on the same edge as state.
    always_ff @(posedge Clock_1us) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            drop_q      <= 1'b0;
            slot_index  <= '0;
            slot_strobe <= '0;
            read_strobe <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            drop_q      <= drop_d;
            slot_index  <= index_d;
            slot_strobe <= (state_d == ST_STROBE) ? (NUM_SLOTS'(1) << index_d) : '0;
            read_strobe <= (state_d == ST_READBACK);
            frame_done  <= (state_d == ST_READBACK);
            aborted     <= aborted_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_periph_frame_sequencer.sv
// tb/tb_periph_frame_sequencer.sv - self-checking bench for periph_frame_sequencer
module tb_periph_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [5:0] req_a, req_b;
    logic [5:0] strobe_a, strobe_b;
    logic [2:0] idx_a, idx_b, st_a, st_b;
    logic       rs_a, rs_b, busy_a, busy_b, fd_a, fd_b, ab_a, ab_b;

    always #5 clk = ~clk;

    periph_frame_sequencer dut_a (
        .Clock_1us   (clk),
        .Rst_n       (rst_n),
        .Enable      (en_a),
        .slot_req    (req_a),
        .slot_strobe (strobe_a),
        .slot_index  (idx_a),
        .read_strobe (rs_a),
        .busy        (busy_a),
        .frame_done  (fd_a),
        .aborted     (ab_a),
        .state       (st_a)
    );

    periph_frame_sequencer #(
        .SETUP_CYCLES (0),
        .STROBE_WIDTH (3),
        .HOLD_CYCLES  (2)
    ) dut_b (
        .Clock_1us   (clk),
        .Rst_n       (rst_n),
        .Enable      (en_b),
        .slot_req    (req_b),
        .slot_strobe (strobe_b),
        .slot_index  (idx_b),
        .read_strobe (rs_b),
        .busy        (busy_b),
        .frame_done  (fd_b),
        .aborted     (ab_b),
        .state       (st_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Expected per-phase outputs; phase j is the cycle after the j-th edge of a frame.
    int e_st[64], e_sb[64], e_idx[64], e_rs[64], e_ab[64];
    int last_ph, cur_ph;
    bit valid, sel_b;

    // Events observed during the last frame, pinned against hand-computed values.
    int first_ph[6], cnt_sb[6], st_at[64];
    int rs_ph, busy_cnt, ab_end;

    logic [5:0] v_sb;
    logic [2:0] v_st, v_idx;
    logic       v_rs, v_fd, v_busy, v_ab;

    assign v_sb   = sel_b ? strobe_b : strobe_a;
    assign v_st   = sel_b ? st_b : st_a;
    assign v_idx  = sel_b ? idx_b : idx_a;
    assign v_rs   = sel_b ? rs_b : rs_a;
    assign v_fd   = sel_b ? fd_b : fd_a;
    assign v_busy = sel_b ? busy_b : busy_a;
    assign v_ab   = sel_b ? ab_b : ab_a;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Frame schedule: enabled slots in ascending order, each taking s+w+h phases.
    // Enable is sampled low first at edge len; phase len-1 tells which part was running.
    task automatic build_model(input logic [5:0] m, input int len, input int s, input int w, input int h);
        int ids[$];
        int per, n, p, k, r, r_ph;
        bit ab;
        for (int i = 0; i < 6; i++) if (m[i]) ids.push_back(i);
        per = s + w + h;
        n   = ids.size();
        p   = len - 1;
        if (p >= n * per) begin
            r_ph = len;
            ab   = 1'b0;
        end else begin
            k    = p / per;
            r    = p % per;
            ab   = 1'b1;
            r_ph = (r < s) ? len : (k + 1) * per;
        end
        last_ph = r_ph + 1;
        for (int j = 0; j <= last_ph; j++) begin
            e_sb[j] = 0; e_idx[j] = 0; e_rs[j] = 0; e_ab[j] = 0;
            if (j > r_ph) e_st[j] = 0;
            else if (j == r_ph) begin
                e_st[j] = 5;
                e_rs[j] = 1;
            end else if (j < n * per) begin
                k = j / per;
                r = j % per;
                e_idx[j] = ids[k];
                if (r < s) e_st[j] = 1;
                else if (r < s + w) begin
                    e_st[j] = 2;
                    e_sb[j] = 1 << ids[k];
                end else e_st[j] = 3;
            end else e_st[j] = 4;
            if (j >= r_ph) e_ab[j] = ab;
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check($sformatf("state@%0d", cur_ph), int'(v_st), e_st[cur_ph]);
            check($sformatf("strobe@%0d", cur_ph), int'(v_sb), e_sb[cur_ph]);
            check($sformatf("read_strobe@%0d", cur_ph), int'(v_rs), e_rs[cur_ph]);
            check($sformatf("frame_done@%0d", cur_ph), int'(v_fd), e_rs[cur_ph]);
            check($sformatf("busy@%0d", cur_ph), int'(v_busy), (e_st[cur_ph] != 0) ? 1 : 0);
            check($sformatf("aborted@%0d", cur_ph), int'(v_ab), e_ab[cur_ph]);
            if (e_st[cur_ph] >= 1 && e_st[cur_ph] <= 3)
                check($sformatf("slot_index@%0d", cur_ph), int'(v_idx), e_idx[cur_ph]);
        end
    end

    task automatic run_frame(input bit b, input logic [5:0] m, input int len,
                             input int s, input int w, input int h);
        build_model(m, len, s, w, h);
        for (int i = 0; i < 6; i++) begin
            first_ph[i] = -1;
            cnt_sb[i]   = 0;
        end
        rs_ph = -1; busy_cnt = 0; ab_end = 0;
        sel_b = b;
        if (b) begin req_b = m; en_b = 1'b1; end
        else   begin req_a = m; en_a = 1'b1; end
        for (int j = 0; j <= last_ph; j++) begin
            @(posedge clk); #1;
            cur_ph = j;
            valid  = 1'b1;
            // Request changes after capture must not affect this frame.
            if (b) req_b = ~m; else req_a = ~m;
            if (j == len - 1) begin
                if (b) en_b = 1'b0; else en_a = 1'b0;
            end
            for (int i = 0; i < 6; i++) begin
                if (v_sb[i]) begin
                    cnt_sb[i]++;
                    if (first_ph[i] < 0) first_ph[i] = j;
                end
            end
            if (v_rs && rs_ph < 0) rs_ph = j;
            if (v_busy) busy_cnt++;
            st_at[j] = int'(v_st);
            ab_end   = int'(v_ab);
        end
        @(negedge clk); #1;
        valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; req_a = '0; req_b = '0;
        valid = 1'b0; sel_b = 1'b0; cur_ph = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state_a", int'(st_a), 0);
        check("reset state_b", int'(st_b), 0);
        check("reset strobes", int'(strobe_a | strobe_b), 0);
        check("reset flags", int'({rs_a, rs_b, fd_a, fd_b, busy_a, busy_b, ab_a, ab_b}), 0);
        check("reset index", int'(idx_a | idx_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full frame, all slots, Enable held 25 cycles.
        run_frame(1'b0, 6'b111111, 25, 1, 1, 1);
        check("t1 slot0 first strobe", first_ph[0], 1);
        check("t1 slot3 first strobe", first_ph[3], 10);
        check("t1 slot5 first strobe", first_ph[5], 16);
        check("t1 slot2 width", cnt_sb[2], 1);
        check("t1 wait_rel at 18", st_at[18], 4);
        check("t1 read_strobe phase", rs_ph, 25);
        check("t1 aborted", ab_end, 0);

        // Sparse mask: skipped slots cost nothing.
        run_frame(1'b0, 6'b010010, 10, 1, 1, 1);
        check("t2 slot1 first strobe", first_ph[1], 1);
        check("t2 slot4 first strobe", first_ph[4], 4);
        check("t2 slot0 never", cnt_sb[0], 0);
        check("t2 slot2 never", cnt_sb[2], 0);

        // Empty mask: straight to WAIT_REL.
        run_frame(1'b0, 6'b000000, 4, 1, 1, 1);
        check("t3 busy cycles", busy_cnt, 5);
        check("t3 read_strobe phase", rs_ph, 4);
        check("t3 wait_rel at 0", st_at[0], 4);

        // Zero setup, wide strobe, two hold cycles.
        run_frame(1'b1, 6'b000001, 10, 0, 3, 2);
        check("t4 slot0 first strobe", first_ph[0], 0);
        check("t4 slot0 width", cnt_sb[0], 3);
        check("t4 hold at 4", st_at[4], 3);
        check("t4 wait_rel at 5", st_at[5], 4);

        // Enable dropped during the strobe of slot 2.
        run_frame(1'b0, 6'b111111, 8, 1, 1, 1);
        check("t5 slot2 width", cnt_sb[2], 1);
        check("t5 slot3 never", cnt_sb[3], 0);
        check("t5 slot5 never", cnt_sb[5], 0);
        check("t5 read_strobe phase", rs_ph, 9);
        check("t5 aborted", ab_end, 1);

        // Reset pulse during the strobe of slot 1, Enable kept high.
        sel_b = 1'b0;
        req_a = 6'b111111;
        en_a  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("t6 strobe slot1 before reset", int'(strobe_a), 2);
        check("t6 state before reset", int'(st_a), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6 reset state", int'(st_a), 0);
        check("t6 reset strobe", int'(strobe_a), 0);
        check("t6 reset flags", int'({rs_a, fd_a, busy_a, ab_a}), 0);
        check("t6 reset index", int'(idx_a), 0);
        rst_n = 1'b1;
        // Restart at slot 0, then release during the setup of slot 1.
        run_frame(1'b0, 6'b111111, 4, 1, 1, 1);
        check("t6 restart slot0 strobe", first_ph[0], 1);
        check("t6 slot1 dropped", cnt_sb[1], 0);
        check("t6 read_strobe phase", rs_ph, 4);
        check("t6 aborted", ab_end, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
